fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter NSTAGE, default 3, producer stages after decode (index 0=E, 1=M, 2=W).
REQ-003 SHALL have parameters MUL_LAT, default 5, and DIV_LAT, default 10, multiply/divide busy cycles.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports issue_valid in 1, issue_dst in 5, issue_tnew in 2: instruction leaving D, its destination, cycles until its result exists in stage 0.
REQ-007 SHALL have ports rs_addr/rt_addr in 5 and rs_tuse/rt_tuse in 2: D-stage sources and cycles until each is consumed.
REQ-008 SHALL have ports rs_pre/rt_pre in DATA_W: register-file read data.
REQ-009 SHALL have port stage_result in NSTAGE*DATA_W: stage k result at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have ports d_is_md in 1, md_start in 1, md_div in 1: D holds mult/div-class instruction; E starts a mult (md_div=0) or div (md_div=1).
REQ-011 SHALL have outputs rs_fwd/rt_fwd out DATA_W: forwarded operands.
REQ-012 SHALL have outputs rs_sel/rt_sel out $clog2(NSTAGE+1): 0 = pre, k+1 = stage k.
REQ-013 SHALL have outputs stall out 1, md_busy out 1, stall_cnt out 32.

Function
REQ-014 SHALL hold per-stage record {valid, dst[4:0], tnew[1:0]}, NSTAGE entries.
REQ-015 Each cycle, stage 0 SHALL load {issue_valid & ~stall, issue_dst, issue_tnew}; stall inserts a bubble (valid=0).
REQ-016 Stage k>0 SHALL load stage k-1 with tnew decremented, saturating at 0; stages never freeze on stall.
REQ-017 Record with dst==0 SHALL never match (register $0 not forwarded).
REQ-018 Match for a source SHALL be the lowest-index valid stage with dst==source addr; older matches are masked.
REQ-019 If matching stage has tnew==0, sel SHALL be k+1 and fwd SHALL be stage_result slice k, same cycle (combinational).
REQ-020 If no match, or matching tnew!=0, sel SHALL be 0 and fwd SHALL equal pre.
REQ-021 Data hazard stall SHALL assert when matching tnew > corresponding tuse, per source, ORed.
REQ-022 md_start SHALL load busy counter with MUL_LAT or DIV_LAT per md_div; counter SHALL decrement to 0 and hold.
REQ-023 md_start while counter nonzero SHALL reload counter with the new latency.
REQ-024 md_busy SHALL equal (counter!=0) | md_start.
REQ-025 stall SHALL equal data-hazard stall | (d_is_md & md_busy).
REQ-026 stall_cnt SHALL increment each cycle stall=1, saturating at 32'hFFFF_FFFF.
REQ-027 Both sources matching same stage SHALL each select independently; simultaneous hazards need no extra arbitration.

Reset
REQ-028 reset SHALL clear all stage valid bits, busy counter and stall_cnt on the next edge, overriding md_start and issue_valid in that cycle.
REQ-029 While reset is high, stall, md_busy SHALL be forced 0 and rs_sel/rt_sel forced 0.
REQ-030 Reset mid-stall or mid-divide SHALL abandon all pending records; first post-reset cycle shows sel=0, stall=0, md_busy=0.

Verification
REQ-031 Issue dst=8,tnew=0; next cycle rs_addr=8,tuse=0, stage_result[0]=32'hDEAD_BEEF -> rs_sel=1, rs_fwd=32'hDEAD_BEEF, stall=0.
REQ-032 Issue lw-like dst=9,tnew=1; next cycle rt_addr=9,rt_tuse=0 -> stall=1 one cycle, then rt_sel=2 with stage_result[1], stall_cnt=1.
REQ-033 Issue dst=5 twice back-to-back (values A then B); rs_addr=5 -> rs_sel=1 (younger B), never older A.
REQ-034 Issue dst=0,tnew=0; rs_addr=0, rs_pre=0 -> rs_sel=0, rs_fwd=0, stall=0.
REQ-035 md_start,md_div=1 at cycle 0; d_is_md=1 held -> stall=1 cycles 0..10, stall=0 cycle 11; md_start md_div=0 -> busy 5 cycles.
REQ-036 Assert reset during divide with counter=6 and stall_cnt=20 -> next cycle md_busy=0, stall=0, stall_cnt=0, all sel=0.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand forwarding select, data-hazard stall and mult/div busy tracking
// Ports: clk/reset (sync, active-high); issue_* describes the instruction leaving D;
// rs_*/rt_* are D-stage source addresses, use times and register-file data;
// stage_result packs the E/M/W results; d_is_md/md_start/md_div drive the mult/div
// busy counter; rs_fwd/rt_fwd and rs_sel/rt_sel are the forwarded operands and their
// sources; stall, md_busy and the saturating stall_cnt report pipeline status.
module fwd_scoreboard #(
   parameter int DATA_W  = 32,
   parameter int NSTAGE  = 3,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        issue_valid,
   input  logic [4:0]                  issue_dst,
   input  logic [1:0]                  issue_tnew,
   input  logic [4:0]                  rs_addr,
   input  logic [4:0]                  rt_addr,
   input  logic [1:0]                  rs_tuse,
   input  logic [1:0]                  rt_tuse,
   input  logic [DATA_W-1:0]           rs_pre,
   input  logic [DATA_W-1:0]           rt_pre,
   input  logic [NSTAGE*DATA_W-1:0]    stage_result,
   input  logic                        d_is_md,
   input  logic                        md_start,
   input  logic                        md_div,
   output logic [DATA_W-1:0]           rs_fwd,
   output logic [DATA_W-1:0]           rt_fwd,
   output logic [$clog2(NSTAGE+1)-1:0] rs_sel,
   output logic [$clog2(NSTAGE+1)-1:0] rt_sel,
   output logic                        stall,
   output logic                        md_busy,
   output logic [31:0]                 stall_cnt
);
   localparam int SW = $clog2(NSTAGE+1);
   logic [NSTAGE-1:0] v;
   logic [4:0]        dst  [NSTAGE];
   logic [1:0]        tnew [NSTAGE];
   logic [31:0]       cnt;
   logic              rs_m, rt_m, rs_ok, rt_ok, hz;
   logic [SW-1:0]     rs_k, rt_k;
   always_ff @(posedge clk) begin
      dst[0]  <= issue_dst;
      tnew[0] <= issue_tnew;
      for (int k = 1; k < NSTAGE; k++) begin
         dst[k]  <= dst[k-1];
         tnew[k] <= tnew[k-1] == 2'd0 ? 2'd0 : tnew[k-1] - 2'd1;
      end
      if (reset) begin
         v         <= '0;
         cnt       <= '0;
         stall_cnt <= '0;
      end else begin
         v[0] <= issue_valid & ~stall;
         for (int k = 1; k < NSTAGE; k++) v[k] <= v[k-1];
         cnt       <= md_start ? 32'(md_div ? DIV_LAT : MUL_LAT) : (cnt != 0 ? cnt - 1 : cnt);
         stall_cnt <= stall_cnt + 32'(stall && ~&stall_cnt);
      end
   end
   // Scan oldest to youngest so the youngest matching producer wins.
   always_comb begin
      rs_m = 1'b0;
      rt_m = 1'b0;
      rs_k = '0;
      rt_k = '0;
      for (int k = NSTAGE-1; k >= 0; k--) begin
         if (v[k] && dst[k] != 5'd0) begin
            if (dst[k] == rs_addr) begin
               rs_m = 1'b1;
               rs_k = SW'(k);
            end
            if (dst[k] == rt_addr) begin
               rt_m = 1'b1;
               rt_k = SW'(k);
            end
         end
      end
      rs_ok   = !reset && rs_m && tnew[rs_k] == 2'd0;
      rt_ok   = !reset && rt_m && tnew[rt_k] == 2'd0;
      rs_sel  = rs_ok ? rs_k + SW'(1) : '0;
      rt_sel  = rt_ok ? rt_k + SW'(1) : '0;
      rs_fwd  = rs_ok ? stage_result[rs_k*DATA_W +: DATA_W] : rs_pre;
      rt_fwd  = rt_ok ? stage_result[rt_k*DATA_W +: DATA_W] : rt_pre;
      hz      = (rs_m && tnew[rs_k] > rs_tuse) || (rt_m && tnew[rt_k] > rt_tuse);
      md_busy = !reset && (cnt != 0 || md_start);
      stall   = !reset && (hz || (d_is_md && md_busy));
   end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;
   logic        clk = 1'b0, reset, issue_valid, d_is_md, md_start, md_div;
   logic [4:0]  issue_dst, rs_addr, rt_addr;
   logic [1:0]  issue_tnew, rs_tuse, rt_tuse, rs_sel, rt_sel;
   logic [31:0] rs_pre, rt_pre, sr0, sr1, sr2, rs_fwd, rt_fwd, stall_cnt;
   logic [95:0] stage_result;
   logic        stall, md_busy;
   int          checks = 0, errors = 0;
   assign stage_result = {sr2, sr1, sr0};
   always #5 clk = ~clk;
   fwd_scoreboard dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_dst(issue_dst),
      .issue_tnew(issue_tnew), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_tuse(rs_tuse),
      .rt_tuse(rt_tuse), .rs_pre(rs_pre), .rt_pre(rt_pre), .stage_result(stage_result),
      .d_is_md(d_is_md), .md_start(md_start), .md_div(md_div), .rs_fwd(rs_fwd),
      .rt_fwd(rt_fwd), .rs_sel(rs_sel), .rt_sel(rt_sel), .stall(stall),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   initial begin
      reset = 1'b1; issue_valid = 1'b0; issue_dst = '0; issue_tnew = '0;
      rs_addr = '0; rt_addr = '0; rs_tuse = '0; rt_tuse = '0; rs_pre = '0; rt_pre = '0;
      sr0 = '0; sr1 = '0; sr2 = '0; d_is_md = 1'b0; md_start = 1'b0; md_div = 1'b0;
      tick; tick;
      md_start = 1'b1; d_is_md = 1'b1; issue_valid = 1'b1;
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_md_busy", 32'(md_busy), 32'd0);
      chk("rst_rs_sel", 32'(rs_sel), 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      tick;
      reset = 1'b0; md_start = 1'b0; d_is_md = 1'b0; issue_valid = 1'b0;
      #1;
      chk("post_rst_md_busy", 32'(md_busy), 32'd0);
      chk("post_rst_stall", 32'(stall), 32'd0);
      // E-stage forwarding of a ready result
      tick;
      issue_valid = 1'b1; issue_dst = 5'd8; issue_tnew = 2'd0;
      tick;
      issue_valid = 1'b0; rs_addr = 5'd8; rs_tuse = 2'd0; rs_pre = 32'h1111; sr0 = 32'hDEAD_BEEF;
      #1;
      chk("e_fwd_sel", 32'(rs_sel), 32'd1);
      chk("e_fwd_data", rs_fwd, 32'hDEAD_BEEF);
      chk("e_fwd_stall", 32'(stall), 32'd0);
      // load-use: one stall, then forward from M
      tick;
      rs_addr = 5'd0; issue_valid = 1'b1; issue_dst = 5'd9; issue_tnew = 2'd1;
      tick;
      issue_valid = 1'b0; rt_addr = 5'd9; rt_tuse = 2'd0; rt_pre = 32'h2222;
      #1;
      chk("lu_stall", 32'(stall), 32'd1);
      chk("lu_sel_pre", 32'(rt_sel), 32'd0);
      chk("lu_fwd_pre", rt_fwd, 32'h2222);
      chk("lu_cnt0", stall_cnt, 32'd0);
      tick;
      sr1 = 32'hCAFE_0001;
      #1;
      chk("lu_sel_m", 32'(rt_sel), 32'd2);
      chk("lu_fwd_m", rt_fwd, 32'hCAFE_0001);
      chk("lu_unstall", 32'(stall), 32'd0);
      chk("lu_cnt1", stall_cnt, 32'd1);
      // two writers of $5: younger wins
      tick;
      rt_addr = 5'd0; issue_valid = 1'b1; issue_dst = 5'd5; issue_tnew = 2'd0;
      tick;
      tick;
      issue_valid = 1'b0; rs_addr = 5'd5; rt_addr = 5'd5; sr0 = 32'hBBBB; sr1 = 32'hAAAA;
      #1;
      chk("young_rs_sel", 32'(rs_sel), 32'd1);
      chk("young_rs_fwd", rs_fwd, 32'hBBBB);
      chk("young_rt_sel", 32'(rt_sel), 32'd1);
      tick;
      sr1 = 32'hBBBB; sr2 = 32'hAAAA;
      #1;
      chk("young_m_sel", 32'(rs_sel), 32'd2);
      chk("young_m_fwd", rs_fwd, 32'hBBBB);
      // $0 is never forwarded
      tick;
      rs_addr = 5'd0; rt_addr = 5'd0; issue_valid = 1'b1; issue_dst = 5'd0; issue_tnew = 2'd0;
      tick;
      issue_valid = 1'b0; rs_pre = 32'd0; sr0 = 32'hFFFF_FFFF;
      #1;
      chk("r0_sel", 32'(rs_sel), 32'd0);
      chk("r0_fwd", rs_fwd, 32'd0);
      chk("r0_stall", 32'(stall), 32'd0);
      // tnew=2 producer against tuse=1 consumer, then aging through M and W
      tick;
      issue_valid = 1'b1; issue_dst = 5'd3; issue_tnew = 2'd2; rs_pre = 32'h3333;
      tick;
      issue_valid = 1'b0; rs_addr = 5'd3; rs_tuse = 2'd1;
      #1;
      chk("t2_stall", 32'(stall), 32'd1);
      chk("t2_sel", 32'(rs_sel), 32'd0);
      chk("t2_fwd", rs_fwd, 32'h3333);
      tick;
      #1;
      chk("t1_stall", 32'(stall), 32'd0);
      chk("t1_sel", 32'(rs_sel), 32'd0);
      tick;
      sr2 = 32'h3333_0003;
      #1;
      chk("t0_sel_w", 32'(rs_sel), 32'd3);
      chk("t0_fwd_w", rs_fwd, 32'h3333_0003);
      // divide: busy for the start cycle plus DIV_LAT cycles
      tick;
      rs_addr = 5'd0; rs_tuse = 2'd0; md_start = 1'b1; md_div = 1'b1; d_is_md = 1'b1;
      #1;
      chk("div_c0_stall", 32'(stall), 32'd1);
      chk("div_c0_busy", 32'(md_busy), 32'd1);
      for (int c = 1; c <= 10; c++) begin
         tick;
         md_start = 1'b0;
         #1;
         chk($sformatf("div_c%0d_stall", c), 32'(stall), 32'd1);
      end
      tick;
      #1;
      chk("div_c11_stall", 32'(stall), 32'd0);
      chk("div_c11_busy", 32'(md_busy), 32'd0);
      chk("div_stall_cnt", stall_cnt, 32'd13);
      // multiply: busy for the start cycle plus MUL_LAT cycles
      tick;
      md_start = 1'b1; md_div = 1'b0;
      #1;
      chk("mul_c0_busy", 32'(md_busy), 32'd1);
      for (int c = 1; c <= 5; c++) begin
         tick;
         md_start = 1'b0;
         d_is_md = (c != 5);
         #1;
         chk($sformatf("mul_c%0d_busy", c), 32'(md_busy), 32'd1);
      end
      chk("mul_no_md_stall", 32'(stall), 32'd0);
      tick;
      #1;
      chk("mul_c6_busy", 32'(md_busy), 32'd0);
      // reset abandons pending records and overrides issue/md_start
      tick;
      issue_valid = 1'b1; issue_dst = 5'd7; issue_tnew = 2'd0;
      tick;
      reset = 1'b1; rs_addr = 5'd7; rs_pre = 32'h7777; md_start = 1'b1; d_is_md = 1'b1;
      #1;
      chk("rrec_sel", 32'(rs_sel), 32'd0);
      chk("rrec_fwd", rs_fwd, 32'h7777);
      chk("rrec_stall", 32'(stall), 32'd0);
      chk("rrec_busy", 32'(md_busy), 32'd0);
      tick;
      reset = 1'b0; issue_valid = 1'b0; md_div = 1'b1;
      #1;
      chk("rrec_sel_after", 32'(rs_sel), 32'd0);
      chk("rrec_cnt", stall_cnt, 32'd0);
      chk("rdiv_c0_busy", 32'(md_busy), 32'd1);
      // restarts at cycles 9 and 15 leave the counter at 6 in cycle 20
      for (int c = 1; c <= 19; c++) begin
         tick;
         md_start = (c == 9 || c == 15);
      end
      tick;
      md_start = 1'b0;
      #1;
      chk("rdiv_c20_cnt", stall_cnt, 32'd20);
      chk("rdiv_c20_busy", 32'(md_busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("rdiv_rst_stall", 32'(stall), 32'd0);
      chk("rdiv_rst_busy", 32'(md_busy), 32'd0);
      tick;
      reset = 1'b0;
      #1;
      chk("rdiv_post_busy", 32'(md_busy), 32'd0);
      chk("rdiv_post_stall", 32'(stall), 32'd0);
      chk("rdiv_post_cnt", stall_cnt, 32'd0);
      chk("rdiv_post_rs_sel", 32'(rs_sel), 32'd0);
      chk("rdiv_post_rt_sel", 32'(rt_sel), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
